fifo_wr_arb_ctrl: RTL and testbench

FIFO_WR_ARB_CTRL -- requirements
Module: fifo_wr_arb_ctrl

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/fifo_wr_arb_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_wr_arb_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and pointer-compare helpers.
package fifo_pkg;

  localparam int DEF_PTR_WD  = 3;
  localparam int DEF_DEPTH   = 1 << DEF_PTR_WD;
  localparam int DEF_DATA_WD = 8;
  localparam int DEF_N_REQ   = 4;

  // Helpers take pointers zero-extended to this width.
  localparam int PTR_MAX_WD  = 16;

  // Number of RAM entries addressed by a pointer of the given width.
  function automatic int depth_of(input int ptr_wd);
    return 1 << ptr_wd;
  endfunction

  // Empty: the pointers match, including the wrap bit.
  function automatic logic ptr_empty(input logic [PTR_MAX_WD-1:0] wp,
                                     input logic [PTR_MAX_WD-1:0] rp);
    return wp == rp;
  endfunction

  // Full: the wrap bits differ and the address bits match.
  // The wrap bit of a ptr_wd-bit address is bit ptr_wd.
  function automatic logic ptr_full(input logic [PTR_MAX_WD-1:0] wp,
                                    input logic [PTR_MAX_WD-1:0] rp,
                                    input int                    ptr_wd);
    logic [PTR_MAX_WD-1:0] x;
    x = wp ^ rp;
    return x == (PTR_MAX_WD'(1) << ptr_wd);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at rr_ptr and wraps modulo N_REQ.
// Produces a one-hot grant and the encoded index of the winner.
module rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int IDX_WD = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [IDX_WD-1:0] rr_ptr,
  output logic [N_REQ-1:0]  gnt,
  output logic [IDX_WD-1:0] gnt_idx
);

  // Scan the offsets from highest to lowest, so the requester nearest rr_ptr wins.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % N_REQ;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_WD'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller with round-robin arbitration among N_REQ writers.
// It drives an external 1-cycle-latency RAM through its pointers and enables.
// The flags are decoded combinationally from the registered pointers.
module fifo_wr_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PTR_WD  = DEF_PTR_WD,
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int N_REQ   = DEF_N_REQ,
  parameter int AF_LVL  = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_WD-1:0] req_data,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     rd_req,
  output logic                     w_enbl,
  output logic [PTR_WD:0]          bin_wr_ptr,
  output logic [DATA_WD-1:0]       ram_wdata,
  output logic                     r_enbl,
  output logic [PTR_WD:0]          bin_rd_ptr,
  output logic                     full_flag,
  output logic                     empty_flag,
  output logic [PTR_WD:0]          count,
  output logic                     almost_full,
  output logic                     underflow_err
);

  localparam int IDX_WD = $clog2(N_REQ);

  // Catch a DEPTH that does not match PTR_WD when the design is elaborated.
  if (DEPTH != depth_of(PTR_WD)) begin : g_depth_chk
    $error("DEPTH must equal 2**PTR_WD");
  end

  logic [PTR_WD:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_WD:0]    rd_ptr_q, rd_ptr_d;
  logic [IDX_WD-1:0]  rr_ptr_q, rr_ptr_d;
  logic               udf_q, udf_d;
  logic [N_REQ-1:0]   req_m;
  logic [IDX_WD-1:0]  gnt_idx;

  assign empty_flag  = ptr_empty(PTR_MAX_WD'(wr_ptr_q), PTR_MAX_WD'(rd_ptr_q));
  assign full_flag   = ptr_full(PTR_MAX_WD'(wr_ptr_q), PTR_MAX_WD'(rd_ptr_q), PTR_WD);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (32'(count) >= AF_LVL);

  // A full FIFO hides every request, so it issues no grant.
  assign req_m = full_flag ? '0 : req;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_WD(IDX_WD)) u_arb (
    .req     (req_m),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign w_enbl        = |gnt;
  assign r_enbl        = rd_req & ~empty_flag;
  assign bin_wr_ptr    = wr_ptr_q;
  assign bin_rd_ptr    = rd_ptr_q;
  assign underflow_err = udf_q;

  // Route the granted requester's slice to the RAM; drive zero when there is no grant.
  always_comb begin
    ram_wdata = '0;
    if (w_enbl) ram_wdata = req_data[gnt_idx*DATA_WD +: DATA_WD];
  end

  // Next-state logic: advance the pointers, rotate the priority, latch underflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_ptr_d = rr_ptr_q;
    udf_d    = udf_q | (rd_req & empty_flag);
    if (w_enbl) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
    if (r_enbl) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // State register; reset clears it at once and logically empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= '0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_ptr_q <= rr_ptr_d;
      udf_q    <= udf_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Bench for fifo_wr_arb_ctrl: directed steps plus random traffic.
// A queue-based reference model and a small RAM model check the outputs.
module tb_fifo_wr_arb_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int PW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int PMOD  = 2 * DEPTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic              rd_req;
  logic              w_enbl, r_enbl, full_flag, empty_flag, almost_full, underflow_err;
  logic [PW:0]       bin_wr_ptr, bin_rd_ptr, count;
  logic [DW-1:0]     ram_wdata;

  always #5 clk = ~clk;

  fifo_wr_arb_ctrl #(.DEPTH(DEPTH), .PTR_WD(PW), .DATA_WD(DW), .N_REQ(N), .AF_LVL(AF)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .rd_req        (rd_req),
    .w_enbl        (w_enbl),
    .bin_wr_ptr    (bin_wr_ptr),
    .ram_wdata     (ram_wdata),
    .r_enbl        (r_enbl),
    .bin_rd_ptr    (bin_rd_ptr),
    .full_flag     (full_flag),
    .empty_flag    (empty_flag),
    .count         (count),
    .almost_full   (almost_full),
    .underflow_err (underflow_err)
  );

  // RAM with 1-cycle read latency, driven by the controller's outputs.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (w_enbl) mem[bin_wr_ptr[PW-1:0]] <= ram_wdata;
    if (r_enbl) rdata <= mem[bin_rd_ptr[PW-1:0]];
  end

  // Reference model: unbounded write/read counts, round-robin pointer, sticky error, data queue.
  int            m_wp, m_rp, m_rr;
  bit            m_udf;
  logic [DW-1:0] m_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_rr = 0; m_udf = 0;
    m_q.delete();
  endtask

  // Assert reset from posedge+1 and check the outputs before any clock edge; release at the next posedge+1.
  task automatic do_reset();
    rst = 1'b1; req = '0; rd_req = 1'b0; req_data = '0;
    #1;
    model_reset();
    chk("rst_gnt",   32'(gnt),           32'd0);
    chk("rst_wen",   32'(w_enbl),        32'd0);
    chk("rst_ren",   32'(r_enbl),        32'd0);
    chk("rst_empty", 32'(empty_flag),    32'd1);
    chk("rst_full",  32'(full_flag),     32'd0);
    chk("rst_count", 32'(count),         32'd0);
    chk("rst_af",    32'(almost_full),   32'd0);
    chk("rst_wptr",  32'(bin_wr_ptr),    32'd0);
    chk("rst_rptr",  32'(bin_rd_ptr),    32'd0);
    chk("rst_udf",   32'(underflow_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive the inputs, compare the outputs with the model, clock it, then check the read data.
  task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic rd, output int gidx);
    int            cnt;
    logic [N-1:0]  eg;
    logic [DW-1:0] ewd;
    logic [DW-1:0] exp_rd;
    logic          er;
    req = r; req_data = d; rd_req = rd;
    #2;
    cnt  = m_wp - m_rp;
    gidx = -1;
    if (cnt != DEPTH)
      for (int k = 0; k < N; k++)
        if (gidx < 0 && r[(m_rr + k) % N]) gidx = (m_rr + k) % N;
    eg = '0; ewd = '0; exp_rd = '0;
    if (gidx >= 0) begin
      eg[gidx] = 1'b1;
      ewd = d[gidx*DW +: DW];
    end
    er = rd && (cnt != 0);
    chk("gnt",       32'(gnt),           32'(eg));
    chk("w_enbl",    32'(w_enbl),        32'(gidx >= 0));
    chk("ram_wdata", 32'(ram_wdata),     32'(ewd));
    chk("r_enbl",    32'(r_enbl),        32'(er));
    chk("full",      32'(full_flag),     32'(cnt == DEPTH));
    chk("empty",     32'(empty_flag),    32'(cnt == 0));
    chk("count",     32'(count),         32'(cnt));
    chk("af",        32'(almost_full),   32'(cnt >= AF));
    chk("wr_ptr",    32'(bin_wr_ptr),    32'(m_wp % PMOD));
    chk("rd_ptr",    32'(bin_rd_ptr),    32'(m_rp % PMOD));
    chk("underflow", 32'(underflow_err), 32'(m_udf));
    if (er) begin
      exp_rd = m_q.pop_front();
      m_rp++;
    end
    if (gidx >= 0) begin
      m_q.push_back(ewd);
      m_wp++;
      m_rr = (gidx + 1) % N;
    end
    if (rd && cnt == 0) m_udf = 1'b1;
    @(posedge clk); #1;
    if (er) chk("rdata", 32'(rdata), 32'(exp_rd));
  endtask

  initial begin
    int            g;
    logic [N*DW-1:0] dv;
    logic [N-1:0]  pend;
    logic [DW-1:0] pd [N];
    int            n_wr;

    rst = 1'b1; req = '0; rd_req = 1'b0; req_data = '0;
    do_reset();

    // All four request together: grants go 0,1,2,3.
    dv = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      step(4'b1111, dv, 1'b0, g);
      chk("rr_order", 32'(gnt_seen(k)), 32'(k));
    end
    chk("count4", 32'(count), 32'd4);

    // Fill to full, then show that writes are blocked and the write pointer holds.
    dv = {8'h88, 8'h77, 8'h66, 8'h55};
    for (int k = 0; k < 4; k++) step(4'b1111, dv, 1'b0, g);
    chk("full8",  32'(full_flag), 32'd1);
    chk("count8", 32'(count),     32'd8);
    step(4'b1111, dv, 1'b0, g);
    chk("wptr_held", 32'(bin_wr_ptr), 32'b1000);

    // Full: a read and requester 2 together. The read goes first; requester 2 is granted next cycle.
    dv = {8'h00, 8'hc2, 8'h00, 8'h00};
    step(4'b0100, dv, 1'b1, g);
    chk("full_rd_cnt", 32'(count), 32'd7);
    step(4'b0100, dv, 1'b0, g);
    chk("full_wr_cnt", 32'(count), 32'd8);

    // Drain everything, then read while empty to trip underflow.
    for (int k = 0; k < 8; k++) step('0, '0, 1'b1, g);
    step('0, '0, 1'b1, g);
    chk("udf_set", 32'(underflow_err), 32'd1);
    step('0, '0, 1'b0, g);
    step('0, '0, 1'b0, g);
    chk("udf_sticky", 32'(underflow_err), 32'd1);

    // Empty: write and read together. The write proceeds; the word is readable next cycle.
    dv = {8'h00, 8'h00, 8'h00, 8'h5a};
    step(4'b0001, dv, 1'b1, g);
    step('0, '0, 1'b1, g);

    // Random traffic; requesters hold request and data until granted.
    pend = '0;
    n_wr = 0;
    for (int k = 0; k < N; k++) pd[k] = '0;
    for (int it = 0; it < 300; it++) begin
      if (it == 150) begin
        do_reset();
        pend = '0;
      end
      for (int k = 0; k < N; k++)
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          pd[k]   = DW'($urandom);
        end
      for (int k = 0; k < N; k++) dv[k*DW +: DW] = pd[k];
      step(pend, dv, ($urandom_range(0, 99) < 45), g);
      if (g >= 0) begin
        pend[g] = 1'b0;
        n_wr++;
      end
    end
    chk("wrapped", 32'(n_wr >= 20), 32'd1);

    // Drain whatever is left and compare the data.
    for (int k = 0; k < DEPTH + 1; k++) step('0, '0, 1'b1, g);
    chk("final_empty", 32'(empty_flag), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Grant index seen in the cycle just stepped: the model's round-robin pointer has moved one past it.
  function automatic int gnt_seen(input int dummy);
    return (m_rr + N - 1) % N + 0 * dummy;
  endfunction

endmodule
